// File: rtl/decoder_10b8b.sv
// 8b/10b code-group decoder: 2-stage pipeline with word-sync FSM.
// Define DECODER_DISP_CHECK_EN to build in running-disparity tracking and disp_err.
//   state | meaning
//   LOSS  | no word alignment, waiting for a K28.5 comma
//   ACQ   | comma seen, counting further commas
//   SYNC  | aligned, counting consecutive bad words
module decoder_10b8b (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic [9:0] entradas,
   output logic [7:0] salidas,
   output logic       K,
   output logic       valid,
   output logic       code_err,
   output logic       disp_err,
   output logic       rd,
   output logic       sync
);
   typedef enum logic [1:0] {LOSS, ACQ, SYNC} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic       s1_valid;
   logic [9:0] s1_data;

   logic [5:0] s6, r6;
   logic [3:0] s4, f4, r4;
   logic       k28, kx7_6b, alt_p, alt_n, a7, bad7;
   logic       err_dec, k_dec, comma, word_bad;
   logic [7:0] byte_dec;

   // returns {legal, EDCBA}
   function automatic logic [5:0] dec6(input logic [5:0] s);
      case (s)
         6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
         6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
         6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
         6'b110001:            dec6 = {1'b1, 5'd3};
         6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
         6'b101001:            dec6 = {1'b1, 5'd5};
         6'b011001:            dec6 = {1'b1, 5'd6};
         6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
         6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
         6'b100101:            dec6 = {1'b1, 5'd9};
         6'b010101:            dec6 = {1'b1, 5'd10};
         6'b110100:            dec6 = {1'b1, 5'd11};
         6'b001101:            dec6 = {1'b1, 5'd12};
         6'b101100:            dec6 = {1'b1, 5'd13};
         6'b011100:            dec6 = {1'b1, 5'd14};
         6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
         6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
         6'b100011:            dec6 = {1'b1, 5'd17};
         6'b010011:            dec6 = {1'b1, 5'd18};
         6'b110010:            dec6 = {1'b1, 5'd19};
         6'b001011:            dec6 = {1'b1, 5'd20};
         6'b101010:            dec6 = {1'b1, 5'd21};
         6'b011010:            dec6 = {1'b1, 5'd22};
         6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
         6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
         6'b100110:            dec6 = {1'b1, 5'd25};
         6'b010110:            dec6 = {1'b1, 5'd26};
         6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
         6'b001110, 6'b001111, 6'b110000: dec6 = {1'b1, 5'd28};
         6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
         6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
         6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
         default:              dec6 = 6'b0;
      endcase
   endfunction

   // returns {legal, HGF}
   function automatic logic [3:0] dec4(input logic [3:0] s);
      case (s)
         4'b1011, 4'b0100: dec4 = {1'b1, 3'd0};
         4'b1001:          dec4 = {1'b1, 3'd1};
         4'b0101:          dec4 = {1'b1, 3'd2};
         4'b1100, 4'b0011: dec4 = {1'b1, 3'd3};
         4'b1101, 4'b0010: dec4 = {1'b1, 3'd4};
         4'b1010:          dec4 = {1'b1, 3'd5};
         4'b0110:          dec4 = {1'b1, 3'd6};
         4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
         default:          dec4 = 4'b0;
      endcase
   endfunction

   assign s6 = {s1_data[0], s1_data[1], s1_data[2], s1_data[3], s1_data[4], s1_data[5]};
   assign s4 = {s1_data[6], s1_data[7], s1_data[8], s1_data[9]};

   always_comb begin
      k28    = (s6 == 6'b001111) || (s6 == 6'b110000);
      // K28 after 110000 carries the complemented fghj of the RD- form
      f4     = (s6 == 6'b110000) ? ~s4 : s4;
      r6     = dec6(s6);
      r4     = dec4(f4);
      kx7_6b = s6 inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                          6'b101110, 6'b010001, 6'b011110, 6'b100001};
      alt_p  = s6 inside {6'b100011, 6'b010011, 6'b001011};
      alt_n  = s6 inside {6'b110100, 6'b101100, 6'b011100};
      a7     = (s4 == 4'b0111) || (s4 == 4'b1000);
      bad7   = (a7 && !(k28 || kx7_6b || (alt_p && s4 == 4'b0111) || (alt_n && s4 == 4'b1000)))
             || (alt_p && s4 == 4'b1110) || (alt_n && s4 == 4'b0001);
      err_dec  = !r6[5] || !r4[3] || bad7;
      k_dec    = !err_dec && (k28 || (kx7_6b && a7));
      byte_dec = err_dec ? 8'h00 : {r4[2:0], r6[4:0]};
      comma    = !err_dec && k28 && (r4[2:0] == 3'd5);
   end

`ifdef DECODER_DISP_CHECK_EN
   logic rd_mid, rd_next, derr6, derr4, dsp_err;

   // 000111/111000 and 0011/1100 are balanced but only legal from one side
   always_comb begin
      if ($countones(s6) > 3)      begin derr6 = rd;  rd_mid = 1'b1; end
      else if ($countones(s6) < 3) begin derr6 = !rd; rd_mid = 1'b0; end
      else if (s6 == 6'b000111)    begin derr6 = !rd; rd_mid = 1'b1; end
      else if (s6 == 6'b111000)    begin derr6 = rd;  rd_mid = 1'b0; end
      else                         begin derr6 = 1'b0; rd_mid = rd; end
      if ($countones(s4) > 2)      begin derr4 = rd_mid;  rd_next = 1'b1; end
      else if ($countones(s4) < 2) begin derr4 = !rd_mid; rd_next = 1'b0; end
      else if (s4 == 4'b0011)      begin derr4 = !rd_mid; rd_next = 1'b1; end
      else if (s4 == 4'b1100)      begin derr4 = rd_mid;  rd_next = 1'b0; end
      else                         begin derr4 = 1'b0; rd_next = rd_mid; end
      dsp_err  = !err_dec && (derr6 || derr4);
      word_bad = err_dec || dsp_err;
   end
`else
   assign disp_err = 1'b0;
   assign rd       = 1'b0;
   always_comb word_bad = err_dec;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= enb;
         if (enb) s1_data <= entradas;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= 1'b0;
         salidas  <= '0;
         K        <= 1'b0;
         code_err <= 1'b0;
         state    <= LOSS;
         cnt      <= '0;
`ifdef DECODER_DISP_CHECK_EN
         disp_err <= 1'b0;
         rd       <= 1'b0;
`endif
      end else begin
         valid <= s1_valid;
         if (s1_valid) begin
            salidas  <= byte_dec;
            K        <= k_dec;
            code_err <= err_dec;
`ifdef DECODER_DISP_CHECK_EN
            disp_err <= dsp_err;
            if (!err_dec) rd <= rd_next;
`endif
            case (state)
               LOSS: if (comma) begin
                  state <= ACQ;
                  cnt   <= 2'd2;
               end
               ACQ: if (err_dec) begin
                  state <= LOSS;
                  cnt   <= '0;
               end else if (comma) begin
                  if (cnt == 2'd0) begin
                     state <= SYNC;
                     cnt   <= 2'd3;
                  end else cnt <= cnt - 2'd1;
               end
               SYNC: if (!word_bad) cnt <= 2'd3;
                  else if (cnt == 2'd0) state <= LOSS;
                  else cnt <= cnt - 2'd1;
               default: begin
                  state <= LOSS;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign sync = (state == SYNC);
endmodule

// File: tb/tb_decoder_10b8b.sv
// Directed-vector bench for decoder_10b8b; expectations follow DECODER_DISP_CHECK_EN.
module tb_decoder_10b8b;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enb = 1'b0;
   logic [9:0] entradas = '0;
   logic [7:0] salidas;
   logic       K, valid, code_err, disp_err, rd, sync;

   int n_vec = 0;
   int n_err = 0;

`ifdef DECODER_DISP_CHECK_EN
   localparam bit DISP = 1'b1;
`else
   localparam bit DISP = 1'b0;
`endif

   decoder_10b8b dut (
      .clk(clk), .rst(rst), .enb(enb), .entradas(entradas),
      .salidas(salidas), .K(K), .valid(valid), .code_err(code_err),
      .disp_err(disp_err), .rd(rd), .sync(sync)
   );

   always #5 clk = ~clk;

   logic [9:0] tv_in  [0:9] = '{10'h0B9, 10'h07C, 10'h057, 10'h3B1, 10'h395,
                                10'h3D5, 10'h3FF, 10'h263, 10'h283, 10'h155};
   logic [7:0] tv_out [0:9] = '{8'h00, 8'hFC, 8'hF7, 8'hF1, 8'h00,
                                8'h00, 8'h00, 8'h23, 8'hBC, 8'hB5};
   logic       tv_k   [0:9] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
   logic       tv_e   [0:9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

   task automatic do_reset();
      rst = 1'b1; enb = 1'b0; entradas = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_vec++; if (valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
      n_vec++; if (salidas !== 8'h00) begin n_err++; $display("FAIL reset_salidas got %h want 00", salidas); end
      n_vec++; if (K !== 1'b0)        begin n_err++; $display("FAIL reset_K got %b want 0", K); end
      n_vec++; if (code_err !== 1'b0) begin n_err++; $display("FAIL reset_code_err got %b want 0", code_err); end
      n_vec++; if (disp_err !== 1'b0) begin n_err++; $display("FAIL reset_disp_err got %b want 0", disp_err); end
      n_vec++; if (rd !== 1'b0)       begin n_err++; $display("FAIL reset_rd got %b want 0", rd); end
      n_vec++; if (sync !== 1'b0)     begin n_err++; $display("FAIL reset_sync got %b want 0", sync); end
      do_reset();
   endtask

   task automatic test_k285();
      do_reset();
      @(negedge clk); enb = 1'b1; entradas = 10'h17C;
      @(negedge clk); enb = 1'b0;
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL k285_early_valid got %b want 0", valid); end
      @(negedge clk);
      n_vec++; if (valid !== 1'b1)     begin n_err++; $display("FAIL k285_valid got %b want 1", valid); end
      n_vec++; if (salidas !== 8'hBC)  begin n_err++; $display("FAIL k285_salidas got %h want bc", salidas); end
      n_vec++; if (K !== 1'b1)         begin n_err++; $display("FAIL k285_K got %b want 1", K); end
      n_vec++; if (code_err !== 1'b0)  begin n_err++; $display("FAIL k285_code_err got %b want 0", code_err); end
      n_vec++; if (disp_err !== 1'b0)  begin n_err++; $display("FAIL k285_disp_err got %b want 0", disp_err); end
      n_vec++; if (rd !== DISP)        begin n_err++; $display("FAIL k285_rd got %b want %b", rd, DISP); end
      @(negedge clk);
      n_vec++; if (valid !== 1'b0)     begin n_err++; $display("FAIL bubble_valid got %b want 0", valid); end
      n_vec++; if (salidas !== 8'hBC)  begin n_err++; $display("FAIL bubble_hold got %h want bc", salidas); end
   endtask

   task automatic test_d215();
      @(negedge clk); enb = 1'b1; entradas = 10'h155;
      @(negedge clk); enb = 1'b0;
      @(negedge clk);
      n_vec++; if (valid !== 1'b1)     begin n_err++; $display("FAIL d215_valid got %b want 1", valid); end
      n_vec++; if (salidas !== 8'hB5)  begin n_err++; $display("FAIL d215_salidas got %h want b5", salidas); end
      n_vec++; if (K !== 1'b0)         begin n_err++; $display("FAIL d215_K got %b want 0", K); end
      n_vec++; if (rd !== DISP)        begin n_err++; $display("FAIL d215_rd got %b want %b", rd, DISP); end
      n_vec++; if (disp_err !== 1'b0)  begin n_err++; $display("FAIL d215_disp_err got %b want 0", disp_err); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk); enb = 1'b1; entradas = 10'h17C;
      @(negedge clk);
      @(negedge clk); enb = 1'b0;
      n_vec++; if (disp_err !== 1'b0) begin n_err++; $display("FAIL b2b_first_disp got %b want 0", disp_err); end
      @(negedge clk);
      n_vec++; if (valid !== 1'b1)    begin n_err++; $display("FAIL b2b_valid got %b want 1", valid); end
      n_vec++; if (disp_err !== DISP) begin n_err++; $display("FAIL b2b_second_disp got %b want %b", disp_err, DISP); end
      n_vec++; if (rd !== DISP)       begin n_err++; $display("FAIL b2b_rd got %b want %b", rd, DISP); end
   endtask

   task automatic test_code_err();
      do_reset();
      @(negedge clk); enb = 1'b1; entradas = 10'h17C;
      @(negedge clk); entradas = 10'h000;
      @(negedge clk); enb = 1'b0;
      @(negedge clk);
      n_vec++; if (code_err !== 1'b1) begin n_err++; $display("FAIL cerr_flag got %b want 1", code_err); end
      n_vec++; if (salidas !== 8'h00) begin n_err++; $display("FAIL cerr_salidas got %h want 00", salidas); end
      n_vec++; if (K !== 1'b0)        begin n_err++; $display("FAIL cerr_K got %b want 0", K); end
      n_vec++; if (rd !== DISP)       begin n_err++; $display("FAIL cerr_rd got %b want %b", rd, DISP); end
   endtask

   task automatic test_table();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); enb = 1'b1; entradas = tv_in[i];
         @(negedge clk); enb = 1'b0;
         @(negedge clk);
         n_vec++; if (salidas !== tv_out[i]) begin n_err++; $display("FAIL tbl_salidas[%0d] in %h got %h want %h", i, tv_in[i], salidas, tv_out[i]); end
         n_vec++; if (K !== tv_k[i])         begin n_err++; $display("FAIL tbl_K[%0d] in %h got %b want %b", i, tv_in[i], K, tv_k[i]); end
         n_vec++; if (code_err !== tv_e[i])  begin n_err++; $display("FAIL tbl_code_err[%0d] in %h got %b want %b", i, tv_in[i], code_err, tv_e[i]); end
      end
   endtask

   task automatic test_sync();
      logic [9:0] w [0:7];
      logic       s [0:7];
      w = '{10'h17C, 10'h283, 10'h17C, 10'h283, 10'h000, 10'h000, 10'h000, 10'h000};
      s = '{0, 0, 0, 1, 1, 1, 1, 0};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            n_vec++; if (valid !== 1'b1)  begin n_err++; $display("FAIL sync_valid[%0d] got %b want 1", c - 2, valid); end
            n_vec++; if (sync !== s[c-2]) begin n_err++; $display("FAIL sync_state[%0d] got %b want %b", c - 2, sync, s[c-2]); end
         end
         if (c < 8) begin enb = 1'b1; entradas = w[c]; end
         else enb = 1'b0;
      end
   endtask

   task automatic test_midstream_reset();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); enb = 1'b1; entradas = c[0] ? 10'h283 : 10'h17C;
      end
      @(negedge clk); enb = 1'b0;
      @(negedge clk);
      n_vec++; if (sync !== 1'b1) begin n_err++; $display("FAIL mid_presync got %b want 1", sync); end
      @(negedge clk); enb = 1'b1; entradas = 10'h155;
      @(negedge clk); entradas = 10'h155;
      #2 rst = 1'b1;
      #1 enb = 1'b0;
      n_vec++; if (valid !== 1'b0)    begin n_err++; $display("FAIL mid_valid got %b want 0", valid); end
      n_vec++; if (salidas !== 8'h00) begin n_err++; $display("FAIL mid_salidas got %h want 00", salidas); end
      n_vec++; if (K !== 1'b0)        begin n_err++; $display("FAIL mid_K got %b want 0", K); end
      n_vec++; if (sync !== 1'b0)     begin n_err++; $display("FAIL mid_sync got %b want 0", sync); end
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL mid_flush[%0d] got %b want 0", c, valid); end
      end
      @(negedge clk); enb = 1'b1; entradas = 10'h155;
      @(negedge clk); enb = 1'b0;
      n_vec++; if (valid !== 1'b0)    begin n_err++; $display("FAIL mid_lat1 got %b want 0", valid); end
      @(negedge clk);
      n_vec++; if (valid !== 1'b1)    begin n_err++; $display("FAIL mid_lat2 got %b want 1", valid); end
      n_vec++; if (salidas !== 8'hB5) begin n_err++; $display("FAIL mid_salidas2 got %h want b5", salidas); end
      n_vec++; if (sync !== 1'b0)     begin n_err++; $display("FAIL mid_loss got %b want 0", sync); end
   endtask

   initial begin
      test_reset();
      test_k285();
      test_d215();
      test_back_to_back();
      test_code_err();
      test_table();
      test_sync();
      test_midstream_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decoder_10b8b.md
DECODER_10B8B -- requirements
Module: decoder_10b8b

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port enb  input  1  entradas holds a code-group this cycle.
REQ-004 SHALL have port entradas  input  10  code-group, bit order j h g f i e d c b a = [9:0].
REQ-005 SHALL have port salidas  output  8  decoded byte, bit order H G F E D C B A = [7:0].
REQ-006 SHALL have port K  output  1  decoded group is a control character.
REQ-007 SHALL have port valid  output  1  salidas/K/code_err/disp_err qualify this cycle.
REQ-008 SHALL have port code_err  output  1  group not in the 8b/10b tables.
REQ-009 SHALL have port disp_err  output  1  running-disparity violation.
REQ-010 SHALL have port rd  output  1  current running disparity, 0 = negative, 1 = positive.
REQ-011 SHALL have port sync  output  1  word-sync FSM is in SYNC.

Function
REQ-012 SHALL be a 2-stage pipeline: stage 1 registers entradas with enb; stage 2 registers decode results; latency 2 cycles from enb to valid.
REQ-013 SHALL assert valid exactly 2 cycles after each cycle with enb=1; enb=0 cycles SHALL propagate as bubbles (valid=0, other outputs hold).
REQ-014 SHALL decode per standard 8b/10b (IEEE 802.3 cl.36) tables: abcdei to EDCBA, fghj to HGF, both disparities accepted.
REQ-015 SHALL set K=1 for K28.0-K28.7, K23.7, K27.7, K29.7, K30.7 only.
REQ-016 SHALL set code_err=1 for any 6b or 4b sub-block not in the tables, including 000000, 111111, 0000, 1111, and illegal K/alternate-D7 combinations; on code_err salidas=8'h00, K=0.
REQ-017 SHALL compute disparity per sub-block: ones count 4 or 5 (6b), 3 (4b) = positive; 2 or 1 = negative; neutral = unchanged, except 000111/111000 and 0011/1100, which force the sign.
REQ-018 SHALL set disp_err=1 when a non-neutral sub-block has the same sign as the running disparity entering it; rd SHALL still update from the received sub-block.
REQ-019 SHALL update rd only on valid words; code_err words SHALL leave rd unchanged.
REQ-020 SHALL implement the sync FSM with states LOSS, ACQ and SYNC; it SHALL advance only on valid words.
REQ-021 FSM transitions SHALL be:
- LOSS -> ACQ on K28.5 (either disparity).
- ACQ -> SYNC after 3 K28.5 commas with no code_err between.
- ACQ -> LOSS on any code_err.
- SYNC -> LOSS after 4 consecutive words with code_err or disp_err; any good word clears the error counter.
REQ-022 SHALL drive sync=1 only in SYNC; the transition SHALL be visible in the same cycle as the valid of the triggering word.

Reset
REQ-023 SHALL on rst=1, asynchronously, clear the pipeline, set salidas=0, K=0, valid=0, code_err=0, disp_err=0, rd=0, sync=0, FSM=LOSS and all counters to 0.
REQ-024 SHALL discard words in flight when reset is asserted mid-stream; the first valid SHALL come 2 cycles after the first enb following rst release.

Configuration
REQ-025 SHALL compile disparity checking in when DECODER_DISP_CHECK_EN is defined, giving REQ-017 to REQ-019 and disp_err counting in REQ-021.
REQ-026 SHALL, with DECODER_DISP_CHECK_EN undefined, tie disp_err=0 and rd=0, omit the disparity logic, and count only code_err in REQ-021.

Verification
REQ-027 Reset, then enb=1 with entradas=10'h17C (K28.5, RD-) -> 2 cycles later: valid=1, salidas=8'hBC, K=1, code_err=0, rd=1.
REQ-028 entradas=10'h155 (D21.5) -> salidas=8'hB5, K=0, rd unchanged, disp_err=0.
REQ-029 Two back-to-back 10'h17C from rd=0 -> second word gives disp_err=1 (macro defined) or disp_err=0 (macro undefined).
REQ-030 entradas=10'h000 -> code_err=1, salidas=8'h00, K=0, rd unchanged.
REQ-031 Four alternating K28.5 words (RD- then RD+, 10'h283) -> sync rises with the 4th valid; then 4 words of 10'h000 -> sync falls with the 4th valid.
REQ-032 rst pulsed while 2 words are in flight -> no valid for those words, outputs at reset values, FSM=LOSS.
